// File: rtl/mod_exp_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mod_exp_ctrl_pkg                                                 |
// | Purpose  : Shared types and defaults for the modular-exponentiation         |
// |            sequencer (FSM state encoding, default operand widths).          |
// | Contents : c_DEF_NBITS / c_DEF_EBITS default widths, state_t FSM encoding.  |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package mod_exp_ctrl_pkg;

  localparam int c_DEF_NBITS = 256;
  localparam int c_DEF_EBITS = 256;

  // 3-bit state encoding shared by everything that inspects the sequencer.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_WAIT_R = 3'd2,
    ST_WAIT_S = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage : mod_exp_ctrl_pkg
`default_nettype wire

// File: rtl/mod_exp_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mod_exp_ctrl_if                                                  |
// | Purpose  : Handshake bus between the exponentiation sequencer and the       |
// |            external modular multiplier (x*y mod n).                         |
// | Signals  : mul_start (pulse), mul_x, mul_y, mul_n (operands, held until     |
// |            mul_done), mul_done (pulse), mul_out (valid with mul_done).      |
// | Modports : master = sequencer side, slave = multiplier side.                |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface mod_exp_ctrl_if
  import mod_exp_ctrl_pkg::*;
#(
  parameter int NBITS = c_DEF_NBITS
);

  logic             mul_start;
  logic [NBITS-1:0] mul_x;
  logic [NBITS-1:0] mul_y;
  logic [NBITS-1:0] mul_n;
  logic             mul_done;
  logic [NBITS-1:0] mul_out;

  modport master (
    output mul_start,
    output mul_x,
    output mul_y,
    output mul_n,
    input  mul_done,
    input  mul_out
  );

  modport slave (
    input  mul_start,
    input  mul_x,
    input  mul_y,
    input  mul_n,
    output mul_done,
    output mul_out
  );

endinterface : mod_exp_ctrl_if
`default_nettype wire

// File: rtl/mod_exp_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mod_exp_ctrl                                                     |
// | Purpose  : Computes base^exp mod n by right-to-left binary square-and-      |
// |            multiply, issuing one multiply at a time to an external          |
// |            modular multiplier over the mul bus.                             |
// | Ports    : clk, rst (async, active high)                                    |
// |            i_start  - 1-cycle request; samples i_base/i_exp/i_n in IDLE     |
// |            i_base   - base (must be < i_n)                                  |
// |            i_exp    - exponent                                              |
// |            i_n      - modulus (must be > 1)                                 |
// |            o_busy   - high from the cycle after an accepted start to done   |
// |            o_done   - 1-cycle pulse, o_out valid in the same cycle          |
// |            o_out    - result, held until the next accepted start            |
// |            mul      - master side of the multiplier handshake               |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module mod_exp_ctrl
  import mod_exp_ctrl_pkg::*;
#(
  parameter int NBITS = c_DEF_NBITS,
  parameter int EBITS = c_DEF_EBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [NBITS-1:0] i_base,
  input  logic [EBITS-1:0] i_exp,
  input  logic [NBITS-1:0] i_n,
  output logic             o_busy,
  output logic             o_done,
  output logic [NBITS-1:0] o_out,
  mod_exp_ctrl_if.master   mul
);

  localparam int              c_CW      = $clog2(EBITS + 1);
  localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(EBITS);

  state_t           r_state;
  logic [NBITS-1:0] r_R;       // running result
  logic [NBITS-1:0] r_B;       // running square of the base
  logic [NBITS-1:0] r_n;
  logic [EBITS-1:0] r_E;       // remaining exponent bits, LSB = current bit
  logic [c_CW-1:0]  r_count;   // squares completed, saturating
  logic             r_busy;
  logic             r_done;
  logic [NBITS-1:0] r_out;
  logic             r_mul_start;
  logic [NBITS-1:0] r_mul_x;
  logic [NBITS-1:0] r_mul_y;
  logic [NBITS-1:0] r_mul_n;
  logic [EBITS-1:0] w_e_shr;

  assign w_e_shr       = r_E >> 1;

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_out         = r_out;
  assign mul.mul_start = r_mul_start;
  assign mul.mul_x     = r_mul_x;
  assign mul.mul_y     = r_mul_y;
  assign mul.mul_n     = r_mul_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_R         <= '0;
      r_B         <= '0;
      r_n         <= '0;
      r_E         <= '0;
      r_count     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_out       <= '0;
      r_mul_start <= 1'b0;
      r_mul_x     <= '0;
      r_mul_y     <= '0;
      r_mul_n     <= '0;
    end else begin
      // Both pulses last exactly one cycle unless re-armed below.
      r_done      <= 1'b0;
      r_mul_start <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_R     <= NBITS'(1);
            r_B     <= i_base;
            r_E     <= i_exp;
            r_n     <= i_n;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          if (r_E == '0) begin
            r_state <= ST_DONE;
          end else if (r_E[0]) begin
            r_mul_x     <= r_R;
            r_mul_y     <= r_B;
            r_mul_n     <= r_n;
            r_mul_start <= 1'b1;
            r_state     <= ST_WAIT_R;
          end else begin
            r_mul_x     <= r_B;
            r_mul_y     <= r_B;
            r_mul_n     <= r_n;
            r_mul_start <= 1'b1;
            r_state     <= ST_WAIT_S;
          end
        end

        ST_WAIT_R: begin
          if (mul.mul_done) begin
            r_R <= mul.mul_out;
            // Last set bit consumed: the square that would follow is never used.
            if (w_e_shr == '0) begin
              r_state <= ST_DONE;
            end else begin
              r_mul_x     <= r_B;
              r_mul_y     <= r_B;
              r_mul_n     <= r_n;
              r_mul_start <= 1'b1;
              r_state     <= ST_WAIT_S;
            end
          end
        end

        ST_WAIT_S: begin
          if (mul.mul_done) begin
            r_B     <= mul.mul_out;
            r_E     <= w_e_shr;
            if (r_count != c_CNT_MAX) begin
              r_count <= r_count + 1'b1;
            end
            r_state <= ST_CHECK;
          end
        end

        ST_DONE: begin
          r_out   <= r_R;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : mod_exp_ctrl
`default_nettype wire

// File: tb/tb_mod_exp_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mod_exp_ctrl                                                  |
// | Purpose  : Self-checking bench for mod_exp_ctrl. Two instances (8-bit and   |
// |            256-bit) each paired with a behavioural multiplier that answers  |
// |            with random latency. Results are compared with a reference pow   |
// |            computed by repeated multiplication.                             |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mod_exp_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       i_start8;
  logic [7:0] i_base8, i_exp8, i_n8, o_out8;
  logic       o_busy8, o_done8;
  mod_exp_ctrl_if #(.NBITS(8)) m8 ();

  mod_exp_ctrl #(.NBITS(8), .EBITS(8)) u_dut8 (
    .clk     (clk),
    .rst     (rst),
    .i_start (i_start8),
    .i_base  (i_base8),
    .i_exp   (i_exp8),
    .i_n     (i_n8),
    .o_busy  (o_busy8),
    .o_done  (o_done8),
    .o_out   (o_out8),
    .mul     (m8)
  );

  // 256-bit instance
  logic         i_start256;
  logic [255:0] i_base256, i_exp256, i_n256, o_out256;
  logic         o_busy256, o_done256;
  mod_exp_ctrl_if #(.NBITS(256)) m256 ();

  mod_exp_ctrl #(.NBITS(256), .EBITS(256)) u_dut256 (
    .clk     (clk),
    .rst     (rst),
    .i_start (i_start256),
    .i_base  (i_base256),
    .i_exp   (i_exp256),
    .i_n     (i_n256),
    .o_busy  (o_busy256),
    .o_done  (o_done256),
    .o_out   (o_out256),
    .mul     (m256)
  );

  int total = 0;
  int bad   = 0;
  int pulses8 = 0, pulses256 = 0;
  int stab8 = 0, stab256 = 0;
  int dcnt8 = 0, dcnt256 = 0;
  int lat_fix = 0;
  bit in_rst = 1'b0;
  int last_lat;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp_v);
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp_v);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b,
                                          input logic [255:0] m);
    logic [511:0] p;
    if (m == '0) return '0;
    p = 512'(a) * 512'(b);
    p = p % 512'(m);
    return p[255:0];
  endfunction

  // base^e mod m by e successive multiplications
  function automatic logic [255:0] pow_ref(input logic [255:0] b, input logic [255:0] e,
                                           input logic [255:0] m);
    logic [255:0] acc;
    acc = 256'd1;
    for (longint unsigned i = 0; 256'(i) < e; i++) acc = mulmod(acc, b, m);
    return acc;
  endfunction

  // one multiply per set bit plus one square per bit position below the top set bit
  function automatic int mul_count(input logic [255:0] e);
    int msb = 0;
    if (e == '0) return 0;
    for (int i = 0; i < 256; i++) if (e[i]) msb = i;
    return $countones(e) + msb;
  endfunction

  // ---------------- multiplier models ----------------
  initial begin : p_multi8
    logic [255:0] x, y, nn, r;
    int lat;
    m8.mul_done = 1'b0;
    m8.mul_out  = '0;
    forever begin
      @(posedge clk);
      if (m8.mul_start === 1'b1) begin
        x = 256'(m8.mul_x); y = 256'(m8.mul_y); nn = 256'(m8.mul_n);
        pulses8++;
        lat = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 20));
        for (int i = 1; i < lat; i++) begin
          @(posedge clk);
          if (!in_rst && (m8.mul_start !== 1'b0 || 256'(m8.mul_x) !== x ||
                          256'(m8.mul_y) !== y || 256'(m8.mul_n) !== nn)) stab8++;
        end
        #1;
        r = mulmod(x, y, nn);
        m8.mul_out  = r[7:0];
        m8.mul_done = 1'b1;
        @(posedge clk);
        #1 m8.mul_done = 1'b0;
      end
    end
  end

  initial begin : p_multi256
    logic [255:0] x, y, nn;
    int lat;
    m256.mul_done = 1'b0;
    m256.mul_out  = '0;
    forever begin
      @(posedge clk);
      if (m256.mul_start === 1'b1) begin
        x = m256.mul_x; y = m256.mul_y; nn = m256.mul_n;
        pulses256++;
        lat = int'($urandom_range(1, 20));
        for (int i = 1; i < lat; i++) begin
          @(posedge clk);
          if (!in_rst && (m256.mul_start !== 1'b0 || m256.mul_x !== x ||
                          m256.mul_y !== y || m256.mul_n !== nn)) stab256++;
        end
        #1;
        m256.mul_out  = mulmod(x, y, nn);
        m256.mul_done = 1'b1;
        @(posedge clk);
        #1 m256.mul_done = 1'b0;
      end
    end
  end

  // done pulses, sampled just after each edge
  always begin
    @(posedge clk);
    #1;
    if (o_done8 === 1'b1)   dcnt8++;
    if (o_done256 === 1'b1) dcnt256++;
  end

  // ---------------- run helpers (called at a negedge) ----------------
  task automatic run8(input logic [7:0] b, input logic [7:0] e, input logic [7:0] nn,
                      input bit poke, output logic [7:0] res, output int lat, output bit busy_ok);
    i_start8 = 1'b1; i_base8 = b; i_exp8 = e; i_n8 = nn;
    @(negedge clk);
    i_start8 = 1'b0;
    busy_ok  = (o_busy8 === 1'b1);
    lat = 0;
    while (o_done8 !== 1'b1 && lat < 2000) begin
      @(negedge clk);
      lat++;
      i_start8 = (poke && lat == 2);
      if (poke && lat == 2) begin
        i_base8 = 8'd2; i_exp8 = 8'd3; i_n8 = 8'd7;
      end
      if (o_done8 !== 1'b1 && o_busy8 !== 1'b1) busy_ok = 1'b0;
    end
    if (o_done8 !== 1'b1) chk("run8_timeout", 256'd0, 256'd1);
    if (o_busy8 !== 1'b0) busy_ok = 1'b0;
    res = o_out8;
  endtask

  task automatic do8(input string tag, input logic [7:0] b, input logic [7:0] e,
                     input logic [7:0] nn, input bit poke, input logic [7:0] expv);
    int p0, d0, lat;
    logic [7:0] res;
    bit busy_ok;
    p0 = pulses8; d0 = dcnt8;
    run8(b, e, nn, poke, res, lat, busy_ok);
    last_lat = lat;
    chk({tag, "_out"},  256'(res), 256'(expv));
    chk({tag, "_muls"}, 256'(pulses8 - p0), 256'(mul_count(256'(e))));
    chk({tag, "_done"}, 256'(dcnt8 - d0), 256'd1);
    chk({tag, "_busy"}, 256'(busy_ok), 256'd1);
  endtask

  task automatic do256(input string tag, input logic [255:0] b, input logic [255:0] e,
                       input logic [255:0] nn, input logic [255:0] expv);
    int p0, d0, lat;
    p0 = pulses256; d0 = dcnt256;
    i_start256 = 1'b1; i_base256 = b; i_exp256 = e; i_n256 = nn;
    @(negedge clk);
    i_start256 = 1'b0;
    lat = 0;
    while (o_done256 !== 1'b1 && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_finished"}, 256'(o_done256), 256'd1);
    chk({tag, "_out"},  o_out256, expv);
    chk({tag, "_muls"}, 256'(pulses256 - p0), 256'(mul_count(e)));
    chk({tag, "_done"}, 256'(dcnt256 - d0), 256'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin : p_main
    int p0, d0, w;
    logic [7:0] nb, bb, eb;
    logic [255:0] big_n, big_b, gold;

    i_start8 = 1'b0; i_base8 = '0; i_exp8 = '0; i_n8 = '0;
    i_start256 = 1'b0; i_base256 = '0; i_exp256 = '0; i_n256 = '0;
    repeat (3) @(negedge clk);

    // reset state, observed while reset is held
    chk("rst_busy",   256'(o_busy8), 256'd0);
    chk("rst_done",   256'(o_done8), 256'd0);
    chk("rst_out",    256'(o_out8), 256'd0);
    chk("rst_mstart", 256'(m8.mul_start), 256'd0);
    chk("rst_mxyn",   256'({m8.mul_x, m8.mul_y, m8.mul_n}), 256'd0);
    chk("rst_out256", o_out256, 256'd0);
    rst = 1'b0;
    @(negedge clk);

    do8("b3e5", 8'd3, 8'd5, 8'd13, 1'b0, 8'd9);
    do8("e0",   8'd7, 8'd0, 8'd11, 1'b0, 8'd1);
    chk("e0_latency", 256'(last_lat), 256'd2);
    do8("e1",   8'd7, 8'd1, 8'd11, 1'b0, 8'd7);

    // second start while busy must be dropped, not queued
    do8("busy_start", 8'd3, 8'd5, 8'd13, 1'b1, 8'd9);
    p0 = pulses8;
    repeat (3) @(negedge clk);
    chk("busy_start_idle",  256'(o_busy8), 256'd0);
    chk("busy_start_nomul", 256'(pulses8 - p0), 256'd0);

    // reset while a square is outstanding; its late result must be ignored
    p0 = pulses8; d0 = dcnt8; lat_fix = 4; in_rst = 1'b1;
    i_start8 = 1'b1; i_base8 = 8'd3; i_exp8 = 8'd5; i_n8 = 8'd13;
    @(negedge clk);
    i_start8 = 1'b0;
    w = 0;
    while (pulses8 < p0 + 2 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk("rst_mid_reach", 256'(pulses8 - p0), 256'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_mid_busy",   256'(o_busy8), 256'd0);
    chk("rst_mid_nodone", 256'(dcnt8 - d0), 256'd0);
    chk("rst_mid_out",    256'(o_out8), 256'd0);
    chk("rst_mid_mxyn",   256'({m8.mul_start, m8.mul_x, m8.mul_y, m8.mul_n}), 256'd0);
    chk("rst_mid_nomul",  256'(pulses8 - p0), 256'd2);
    lat_fix = 0; in_rst = 1'b0;
    do8("after_rst", 8'd2, 8'd10, 8'd250, 1'b0, 8'd24);
    do256("after_rst256", 256'd2, 256'd10, 256'd1000, 256'd24);

    // random operands against the repeated-multiplication model
    for (int i = 0; i < 12; i++) begin
      nb = 8'($urandom_range(2, 255));
      bb = 8'($urandom % 32'(nb));
      eb = 8'($urandom_range(0, 255));
      do8($sformatf("rnd%0d", i), bb, eb, nb, 1'b0, pow_ref(256'(bb), 256'(eb), 256'(nb)));
    end

    // full-width run with the common public exponent
    for (int i = 0; i < 8; i++) begin
      big_n[i*32 +: 32] = $urandom;
      big_b[i*32 +: 32] = $urandom;
    end
    big_n[255] = 1'b1;
    big_n[0]   = 1'b1;
    big_b      = big_b % big_n;
    gold       = pow_ref(big_b, 256'd65537, big_n);
    do256("e65537", big_b, 256'd65537, big_n, gold);

    chk("operand_stable8",   256'(stab8), 256'd0);
    chk("operand_stable256", 256'(stab256), 256'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : p_watchdog
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule : tb_mod_exp_ctrl
`default_nettype wire
